// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-and-issue stage feeding the integer ALU over valid/ready.
// Optional macro ALU_ISSUE_SKID_EN selects a two-entry skid buffer instead of a single register.
`default_nettype none

module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_d1,
  output logic [XLEN-1:0] alu_d2,
  output logic            out_illegal,
  output logic [31:0]     issue_count
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_AND  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic            ill;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
  } entry_t;

  // Register-register and register-immediate forms share the funct3 mapping.
  function automatic logic [3:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_ctrl = ALU_ADD;
      3'b001:  f3_ctrl = ALU_SLL;
      3'b010:  f3_ctrl = ALU_SLT;
      3'b011:  f3_ctrl = ALU_SLTU;
      3'b100:  f3_ctrl = ALU_XOR;
      3'b101:  f3_ctrl = ALU_SRL;
      3'b110:  f3_ctrl = ALU_OR;
      default: f3_ctrl = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            unused_rs1_field;
  entry_t          dec;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign shamt  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
  assign unused_rs1_field = ^in_instr[19:15];

  always_comb begin
    dec = '0;
    case (opcode)
      OPC_OP: begin
        dec.d1 = in_rs1;
        dec.d2 = in_rs2;
        if (funct7 == F7_BASE)                         dec.ctrl = f3_ctrl(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) dec.ctrl = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) dec.ctrl = ALU_SRA;
        else                                           dec.ill  = 1'b1;
      end
      OPC_OPIMM: begin
        dec.d1 = in_rs1;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec.d2 = shamt;
          if (funct7 == F7_BASE)                         dec.ctrl = f3_ctrl(funct3);
          else if (funct7 == F7_ALT && funct3 == 3'b101) dec.ctrl = ALU_SRA;
          else                                           dec.ill  = 1'b1;
        end else begin
          dec.d2   = imm_i;
          dec.ctrl = f3_ctrl(funct3);
        end
      end
      OPC_LUI: dec.d2 = imm_u;
      OPC_AUIPC: begin
        dec.d1 = in_pc;
        dec.d2 = imm_u;
      end
      OPC_LOAD: begin
        dec.d1 = in_rs1;
        dec.d2 = imm_i;
      end
      OPC_STORE: begin
        dec.d1 = in_rs1;
        dec.d2 = imm_s;
      end
      OPC_BRANCH: begin
        dec.d1 = in_rs1;
        dec.d2 = in_rs2;
        case (funct3[2:1])
          2'b00:   dec.ctrl = ALU_SUB;
          2'b10:   dec.ctrl = ALU_SLT;
          2'b11:   dec.ctrl = ALU_SLTU;
          default: dec.ill  = 1'b1;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        dec.d1 = in_pc;
        dec.d2 = XLEN'(4);
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal entries carry no operands so the ALU sees a harmless ADD of zeros.
    if (dec.ill) begin
      dec.ctrl = ALU_ADD;
      dec.d1   = '0;
      dec.d2   = '0;
    end
  end

  entry_t      out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] count_q, count_d;
  logic        accept;
  logic        consume;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid_q && out_ready;
  assign count_d = count_q + 32'(consume);

`ifdef ALU_ISSUE_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   rdy_q, rdy_d;

  assign in_ready = rdy_q && !flush;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume || !out_valid_q) begin
      // Output slot frees up: the older skid entry moves forward first.
      if (skid_valid_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    rdy_d = !(out_valid_d && skid_valid_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      rdy_q        <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      rdy_q        <= rdy_d;
    end
  end
`else
  assign in_ready = !flush && (!out_valid_q || out_ready);

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = dec;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = out_q.ctrl;
  assign alu_d1      = out_q.d1;
  assign alu_d2      = out_q.d2;
  assign out_illegal = out_q.ill;
  assign issue_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized bench for alu_issue against a queue-based reference model.
`default_nettype none

module tb_alu_issue;

`ifdef ALU_ISSUE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int DEPTH = SKID ? 2 : 1;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic [31:0] alu_d1;
  logic [31:0] alu_d2;
  logic        out_illegal;
  logic [31:0] issue_count;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_control(alu_control), .alu_d1(alu_d1), .alu_d2(alu_d2),
    .out_illegal(out_illegal), .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ill;
    logic [3:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t        q[$];
  logic [31:0] cnt_model;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural decode straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs1,
                                      input logic [31:0] rs2, input logic [31:0] pc);
    logic [3:0]  f3map [8];
    logic [3:0]  brmap [8];
    logic [31:0] imm_i, imm_s, imm_u;
    logic [2:0]  f3;
    logic [6:0]  f7;
    exp_t        r;
    f3map = '{4'd0, 4'd5, 4'd2, 4'd3, 4'd10, 4'd6, 4'd9, 4'd8};
    brmap = '{4'd1, 4'd1, 4'd15, 4'd15, 4'd2, 4'd2, 4'd3, 4'd3};
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = $signed(ins) >>> 20;
    imm_s = (imm_i & ~32'h1F) | 32'(ins[11:7]);
    imm_u = ins & 32'hFFFF_F000;
    r     = '0;
    case (ins[6:0])
      7'h33: begin
        r.d1 = rs1; r.d2 = rs2;
        if (f7 == 7'h00)                  r.ctrl = f3map[f3];
        else if (f7 == 7'h20 && f3 == 0)  r.ctrl = 4'd1;
        else if (f7 == 7'h20 && f3 == 5)  r.ctrl = 4'd7;
        else                              r.ill  = 1'b1;
      end
      7'h13: begin
        r.d1 = rs1;
        if (f3 == 1 || f3 == 5) begin
          r.d2 = 32'(ins[24:20]);
          if (f7 == 7'h00)                 r.ctrl = f3map[f3];
          else if (f7 == 7'h20 && f3 == 5) r.ctrl = 4'd7;
          else                             r.ill  = 1'b1;
        end else begin
          r.d2 = imm_i; r.ctrl = f3map[f3];
        end
      end
      7'h37: begin r.d1 = 0;   r.d2 = imm_u; end
      7'h17: begin r.d1 = pc;  r.d2 = imm_u; end
      7'h03: begin r.d1 = rs1; r.d2 = imm_i; end
      7'h23: begin r.d1 = rs1; r.d2 = imm_s; end
      7'h63: begin
        r.d1 = rs1; r.d2 = rs2;
        if (brmap[f3] == 4'd15) r.ill = 1'b1;
        else                    r.ctrl = brmap[f3];
      end
      7'h6F, 7'h67: begin r.d1 = pc; r.d2 = 32'd4; end
      default: r.ill = 1'b1;
    endcase
    if (r.ill) r = '{ill: 1'b1, ctrl: 4'd0, d1: 32'd0, d2: 32'd0};
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  opcs [10];
    logic [6:0]  f7s  [3];
    int          k;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h13};
    w    = $urandom;
    k    = $urandom_range(0, 11);
    if (k < 10) w[6:0] = opcs[k];
    f7s = '{7'h00, 7'h20, 7'($urandom)};
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[31:25] = f7s[$urandom_range(0, 2)];
    return w;
  endfunction

  // One clock of stimulus: checks outputs, drives inputs, advances the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] pc,
                      input logic ordy, input logic fl, output logic acc);
    logic exp_rdy;
    logic cons;
    exp_t e;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("issue_count", issue_count, cnt_model);
    if (q.size() != 0) begin
      check("alu_control", 32'(alu_control), 32'(q[0].ctrl));
      check("alu_d1", alu_d1, q[0].d1);
      check("alu_d2", alu_d2, q[0].d2);
      check("out_illegal", 32'(out_illegal), 32'(q[0].ill));
    end
    in_valid = v; in_instr = ins; in_rs1 = rs1; in_rs2 = rs2; in_pc = pc;
    out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (SKID ? (q.size() < 2) : (q.size() == 0 || ordy));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc  = v && exp_rdy;
    cons = (q.size() != 0) && ordy;
    e    = ref_decode(ins, rs1, rs2, pc);
    @(posedge clk);
    if (cons) begin
      void'(q.pop_front());
      cnt_model++;
    end
    if (fl)       q.delete();
    else if (acc) q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_step(input logic v, input logic ordy, input logic fl, output logic acc);
    step(v, gen_instr(), $urandom, $urandom, $urandom & 32'hFFFF_FFFC, ordy, fl, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    int          taken;
    int          guard;
    logic [31:0] base;
    logic [3:0]  pat;
    n_vec = 0; n_err = 0; cnt_model = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_rs1 = '0; in_rs2 = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_control", 32'(alu_control), 0);
    check("rst_d1", alu_d1, 0);
    check("rst_d2", alu_d2, 0);
    check("rst_illegal", 32'(out_illegal), 0);
    check("rst_count", issue_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    step(1, 32'h002081B3, 32'd5, 32'd7, 32'h100, 1, 0, acc);
    check("add_valid", 32'(out_valid), 1);
    check("add_ctrl", 32'(alu_control), 4'b0000);
    check("add_d1", alu_d1, 32'd5);
    check("add_d2", alu_d2, 32'd7);
    check("add_ill", 32'(out_illegal), 0);
    step(1, 32'h4030D093, 32'h8000_0000, 32'd0, 32'h104, 1, 0, acc);
    check("add_count", issue_count, 32'd1);
    check("srai_ctrl", 32'(alu_control), 4'b0111);
    check("srai_d2", alu_d2, 32'd3);
    step(1, 32'h123450B7, 32'hDEAD_BEEF, 32'd0, 32'h108, 1, 0, acc);
    check("lui_ctrl", 32'(alu_control), 4'b0000);
    check("lui_d1", alu_d1, 32'd0);
    check("lui_d2", alu_d2, 32'h1234_5000);
    step(1, 32'h0020E463, 32'd1, 32'd2, 32'h10C, 1, 0, acc);
    check("bltu_ctrl", 32'(alu_control), 4'b0011);
    step(1, 32'h0000007F, 32'h55, 32'h66, 32'h110, 1, 0, acc);
    check("illegal_flag", 32'(out_illegal), 1);
    check("illegal_ctrl", 32'(alu_control), 0);
    check("illegal_d1", alu_d1, 0);
    check("illegal_d2", alu_d2, 0);
    step(0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, acc);
    check("directed_count", issue_count, 32'd5);

    // Back-to-back entries with out_ready following 1,0,0,1.
    pat = 4'b1001;
    base = cnt_model; taken = 0; guard = 0;
    while (taken < 8 && guard < 64) begin
      rand_step(1, pat[3 - (guard % 4)], 0, acc);
      if (acc) taken++;
      guard++;
    end
    check("b2b_accepted", 32'(taken), 32'd8);
    guard = 0;
    while (q.size() != 0 && guard < 16) begin
      rand_step(0, 1, 0, acc);
      guard++;
    end
    check("b2b_count", issue_count, base + 32'd8);

    // Fill the stage, then flush with a pending request and a stalled consumer.
    guard = 0;
    while (q.size() < DEPTH && guard < 8) begin
      rand_step(1, 0, 0, acc);
      guard++;
    end
    base = cnt_model;
    rand_step(1, 0, 1, acc);
    check("flush_valid", 32'(out_valid), 0);
    check("flush_count", issue_count, base);
    check("flush_accept", 32'(acc), 0);

    for (int i = 0; i < 300; i++) begin
      rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 39) == 0, acc);
    end

    // Asynchronous reset mid-stream with an entry held.
    guard = 0;
    while (q.size() == 0 && guard < 8) begin
      rand_step(1, 0, 0, acc);
      guard++;
    end
    check("pre_reset_valid", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_ctrl", 32'(alu_control), 0);
    check("mid_rst_d1", alu_d1, 0);
    check("mid_rst_d2", alu_d2, 0);
    check("mid_rst_ill", 32'(out_illegal), 0);
    check("mid_rst_count", issue_count, 0);
    q.delete();
    cnt_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      rand_step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 1'b0, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that produces the operand and control stream consumed by the RV32I integer ALU. It accepts one instruction word with its register-file read data and PC over a valid/ready handshake, decodes the ALU operation code and operand pair, and presents them, registered, to the ALU on a second valid/ready interface. It sits between register read and the ALU/execute stage, and it keeps a running count of issued operations.

## Interface
- XLEN, 32, datapath width. Only 32 is supported.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous: discard all held entries
- in_valid  in  1  upstream request
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_rs1  in  32  rs1 read data
- in_rs2  in  32  rs2 read data
- in_pc  in  32  instruction address
- out_valid  out  1  issue entry available
- out_ready  in  1  ALU/execute consumes entry
- alu_control  out  4  ALU operation code
- alu_d1  out  32  ALU operand 1
- alu_d2  out  32  ALU operand 2
- out_illegal  out  1  entry decoded from an unsupported encoding
- issue_count  out  32  number of entries consumed by downstream, wraps at 2^32

## Operation
- ALU codes: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, SLL 0101, SRL 0110, SRA 0111, AND 1000, OR 1001, XOR 1010. Code 0100 is never issued.
- OP (0110011): d1=rs1, d2=rs2. funct7=0000000 with funct3 000/001/010/011/100/101/110/111 issues ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND. funct7=0100000 with funct3 000 issues SUB; with funct3 101 it issues SRA.
- OP-IMM (0010011): d1=rs1, d2=sign-extended instr[31:20]. Shifts (funct3 001/101) use d2={27'b0, instr[24:20]}; instr[30]=1 with funct3 101 issues SRA.
- LUI: d1=0, d2={instr[31:12],12'b0}, ADD. AUIPC: d1=pc, same d2, ADD.
- LOAD: ADD of rs1 and the I-immediate. STORE: ADD of rs1 and the S-immediate {instr[31:25],instr[11:7]}, sign-extended.
- BRANCH: d1=rs1, d2=rs2. BEQ/BNE issue SUB, BLT/BGE issue SLT, BLTU/BGEU issue SLTU.
- JAL/JALR: d1=pc, d2=4, ADD (link value).
- Illegal encodings set out_illegal=1 with control 0000 and d1=d2=0. These cover unknown opcodes, OP with any other funct7/funct3 combination, OP-IMM shifts with a nonzero funct7 other than SRAI's, and branch funct3 010/011. Illegal entries still flow through the handshake and are counted.
- Transfer rules: input accepted when in_valid&&in_ready. Output consumed when out_valid&&out_ready.
- issue_count increments by 1 on each output consumption.
- Held entries never change until consumed; downstream may rely on stable outputs while out_valid&&!out_ready.

## Timing
- Latency: an entry accepted at edge N is visible with out_valid=1 after edge N.
- Sustained throughput is one entry per cycle when out_ready stays high.
- Reset (async assert, sync release) sets out_valid=0, alu_control=0, alu_d1=0, alu_d2=0, out_illegal=0 and issue_count=0. in_ready=1 while rst_n is high after reset.
- Mid-operation reset drops all held entries immediately; no consumption is counted.
- flush=1 at an edge empties the stage and forbids acceptance at that edge. A consumption at the same edge is still counted. in_ready is 0 during flush.
- Accept and consume at the same edge with the stage full: the held entry leaves and the new one is loaded. Nothing is lost or duplicated.

## Configuration
- ALU_ISSUE_SKID_EN defined: two-entry skid buffer.
  - in_ready is a register output with no combinational path from out_ready; in_ready=0 only when both entries are full.
  - Entries leave in order.
- Not defined: single pipeline register with in_ready = !out_valid || out_ready (combinational path).
- Both variants: same latency, same decode, same flush and counter behaviour.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> one cycle later out_valid=1, control=0000, d1=5, d2=7, illegal=0; issue_count=1 after consumption.
- srai (0x4030D093), rs1=0x80000000 -> control=0111, d2=3. lui 0x12345 -> d1=0, d2=0x12345000, control=0000.
- bltu (0x0020E463), rs1=1, rs2=2 -> control=0011. Opcode 0x7F -> illegal=1, control=0000, d1=d2=0, still counted.
- Back-to-back 8 valid entries while out_ready toggles 1,0,0,1,... -> all 8 outputs in order, stable while stalled; issue_count=8. With ALU_ISSUE_SKID_EN, in_ready stays 1 until both entries are full.
- Stage full, flush=1 while in_valid=1 and out_ready=0 -> next cycle out_valid=0, input not accepted, issue_count unchanged.
- rst_n pulsed low mid-stream with out_valid=1 -> all outputs 0 and issue_count=0 during reset; in_ready=1 after release.
